// File: rtl/dca_matrix_lsu_arbiter.sv
// dca_matrix_lsu_arbiter: round-robin share of one LSU instruction port, with
// an outstanding-ID FIFO that routes in-order LSU completions back to issuers.
module dca_matrix_lsu_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int BW_INST         = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              enable,
    input  logic [NUM_REQ-1:0]                req_inst_wvalid,
    output logic [NUM_REQ-1:0]                req_inst_wready,
    input  logic [NUM_REQ*BW_INST-1:0]        req_inst_wdata,
    output logic [NUM_REQ-1:0]                req_inst_done,
    output logic                              lsu_inst_wvalid,
    input  logic                              lsu_inst_wready,
    output logic [BW_INST-1:0]                lsu_inst_wdata,
    input  logic                              lsu_inst_done,
    output logic                              busy,
    output logic [$clog2(MAX_OUTSTANDING):0]  num_outstanding,
    output logic                              error_unexpected_done
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    logic [IW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, done_idx_q, done_idx_d;
    logic [IW-1:0] grant, low, hi, sel;
    logic          lock_q, lock_d, done_pending_q, done_pending_d, err_q, err_d;
    logic          hi_ok, can_issue, push, pop;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Lowest valid at or above rr_ptr wins, else wrap to the lowest valid overall.
    always_comb begin
        low   = '0;
        hi    = '0;
        hi_ok = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_inst_wvalid[i]) begin
                low = IW'(i);
                if (IW'(i) >= rr_q) begin
                    hi    = IW'(i);
                    hi_ok = 1'b1;
                end
            end
        end
        grant = lock_q ? lock_idx_q : (hi_ok ? hi : low);
    end

    assign can_issue       = enable & (cnt_q < CW'(MAX_OUTSTANDING)) & req_inst_wvalid[grant];
    assign sel             = can_issue ? grant : low;
    assign lsu_inst_wvalid = can_issue;
    assign lsu_inst_wdata  = req_inst_wdata[int'(sel)*BW_INST +: BW_INST];
    assign req_inst_wready = can_issue ? (NUM_REQ'(lsu_inst_wready) << grant) : '0;
    assign req_inst_done   = NUM_REQ'(done_pending_q) << done_idx_q;
    assign busy            = (cnt_q != '0) | (|req_inst_wvalid);
    assign num_outstanding = cnt_q;
    assign error_unexpected_done = err_q;

    assign push = lsu_inst_wvalid & lsu_inst_wready;
    assign pop  = lsu_inst_done & (cnt_q != '0);

    always_comb begin
        rr_d           = push ? ((grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1) : rr_q;
        lock_d         = push ? 1'b0 : (lsu_inst_wvalid | lock_q);
        lock_idx_d     = (lsu_inst_wvalid & ~lsu_inst_wready) ? grant : lock_idx_q;
        wr_d           = wr_q + AW'(push);
        rd_d           = rd_q + AW'(pop);
        cnt_d          = cnt_q + CW'(push) - CW'(pop);
        done_pending_d = pop;
        done_idx_d     = pop ? fifo_q[rd_q] : done_idx_q;
        err_d          = err_q | (lsu_inst_done & (cnt_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q           <= '0;
            lock_q         <= 1'b0;
            lock_idx_q     <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            cnt_q          <= '0;
            done_pending_q <= 1'b0;
            done_idx_q     <= '0;
            err_q          <= 1'b0;
        end else if (clear) begin
            rr_q           <= '0;
            lock_q         <= 1'b0;
            lock_idx_q     <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            cnt_q          <= '0;
            done_pending_q <= 1'b0;
            done_idx_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            rr_q           <= rr_d;
            lock_q         <= lock_d;
            lock_idx_q     <= lock_idx_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            cnt_q          <= cnt_d;
            done_pending_q <= done_pending_d;
            done_idx_q     <= done_idx_d;
            err_q          <= err_d;
        end
    end

    // FIFO storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push && !clear)
            fifo_q[wr_q] <= grant;
    end
endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
// tb_dca_matrix_lsu_arbiter: vector table for the combinational grant path plus
// scoreboarded sequences for ordering, lock, full, clear, error and reset.
module tb_dca_matrix_lsu_arbiter;
    logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, enable = 1'b0;
    logic [1:0]  req_inst_wvalid = '0, req_inst_wready, req_inst_done;
    logic [63:0] req_inst_wdata;
    logic        lsu_inst_wvalid, lsu_inst_wready = 1'b0, lsu_inst_done = 1'b0;
    logic [31:0] lsu_inst_wdata;
    logic        busy, error_unexpected_done;
    logic [2:0]  num_outstanding;

    logic [31:0] dat [2];
    int          checks = 0, errors = 0;
    int          sb[$];
    int          pend;
    logic        exp_err = 1'b0;

    typedef struct {
        logic       en;
        logic [1:0] v;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_wready;
        int         exp_sel;
    } vec_t;
    vec_t tbl [8];

    assign req_inst_wdata = {dat[1], dat[0]};

    dca_matrix_lsu_arbiter #(.NUM_REQ(2), .BW_INST(32), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable),
        .req_inst_wvalid(req_inst_wvalid), .req_inst_wready(req_inst_wready),
        .req_inst_wdata(req_inst_wdata), .req_inst_done(req_inst_done),
        .lsu_inst_wvalid(lsu_inst_wvalid), .lsu_inst_wready(lsu_inst_wready),
        .lsu_inst_wdata(lsu_inst_wdata), .lsu_inst_done(lsu_inst_done),
        .busy(busy), .num_outstanding(num_outstanding),
        .error_unexpected_done(error_unexpected_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; g is the requester expected to be granted, -1 for none.
    task automatic tick(input string nm, input logic [1:0] v, input logic e, input logic r,
                        input logic dn, input logic c, input int g);
        logic [1:0] ew;
        req_inst_wvalid = v;
        enable          = e;
        lsu_inst_wready = r;
        lsu_inst_done   = dn;
        clear           = c;
        #3;
        ew = (g >= 0 && r) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
        check({nm, ".valid"}, 64'(lsu_inst_wvalid), 64'(g >= 0));
        check({nm, ".wready"}, 64'(req_inst_wready), 64'(ew));
        check({nm, ".count"}, 64'(num_outstanding), 64'(sb.size()));
        if (g >= 0)
            check({nm, ".wdata"}, 64'(lsu_inst_wdata), 64'(dat[g]));
        pend = -1;
        if (c) begin
            sb.delete();
            exp_err = 1'b0;
        end else begin
            if (dn) begin
                if (sb.size() > 0) pend = sb.pop_front();
                else exp_err = 1'b1;
            end
            if (g >= 0 && r && e) sb.push_back(g);
        end
        @(posedge clk);
        #1;
        check({nm, ".done"}, 64'(req_inst_done), (pend >= 0) ? 64'(1 << pend) : 64'd0);
        check({nm, ".err"}, 64'(error_unexpected_done), 64'(exp_err));
    endtask

    initial begin
        dat[0] = 32'hAAAA_0000;
        dat[1] = 32'hBBBB_1111;
        tbl[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 2'b00, -1};
        tbl[1] = '{1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 0};
        tbl[2] = '{1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 1};
        tbl[3] = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b01, 0};
        tbl[4] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 0};
        tbl[5] = '{1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 0};
        tbl[6] = '{1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1};
        tbl[7] = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1};

        #12;
        check("rst.valid", 64'(lsu_inst_wvalid), 64'd0);
        check("rst.count", 64'(num_outstanding), 64'd0);
        check("rst.err", 64'(error_unexpected_done), 64'd0);
        check("rst.done", 64'(req_inst_done), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clear held high so no table vector changes state.
        clear = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            enable          = tbl[i].en;
            req_inst_wvalid = tbl[i].v;
            lsu_inst_wready = tbl[i].rdy;
            #3;
            check($sformatf("tbl%0d.valid", i), 64'(lsu_inst_wvalid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d.wready", i), 64'(req_inst_wready), 64'(tbl[i].exp_wready));
            check($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].v != 2'b00));
            if (tbl[i].exp_sel >= 0)
                check($sformatf("tbl%0d.wdata", i), 64'(lsu_inst_wdata), 64'(dat[tbl[i].exp_sel]));
        end
        @(posedge clk);
        #1;

        // Round robin to full, then blocked.
        tick("rr0", 2'b11, 1, 1, 0, 0, 0);
        tick("rr1", 2'b11, 1, 1, 0, 0, 1);
        tick("rr2", 2'b11, 1, 1, 0, 0, 0);
        tick("rr3", 2'b11, 1, 1, 0, 0, 1);
        tick("full0", 2'b11, 1, 1, 0, 0, -1);
        tick("full1", 2'b11, 1, 1, 0, 0, -1);
        // Done at full: no issue this cycle, issue next.
        tick("fulldone", 2'b11, 1, 1, 1, 0, -1);
        tick("fullnext", 2'b11, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick($sformatf("drain%0d", i), 2'b00, 1, 1, 1, 0, -1);

        // Push and pop together at count 2.
        tick("sim0", 2'b11, 1, 1, 0, 0, 1);
        tick("sim1", 2'b11, 1, 1, 0, 0, 0);
        tick("simpp", 2'b11, 1, 1, 1, 0, 1);
        tick("simd0", 2'b00, 1, 1, 1, 0, -1);
        tick("simd1", 2'b00, 1, 1, 1, 0, -1);

        // Lock: rr points at 1, req0 stalls, req1 rises, enable dips.
        tick("lk0", 2'b01, 1, 1, 0, 0, 0);
        tick("lk1", 2'b01, 1, 0, 0, 0, 0);
        tick("lk2", 2'b01, 1, 0, 0, 0, 0);
        tick("lk3", 2'b01, 1, 0, 0, 0, 0);
        tick("lk4", 2'b11, 1, 0, 0, 0, 0);
        tick("lken", 2'b11, 0, 1, 0, 0, -1);
        tick("lk5", 2'b11, 1, 0, 0, 0, 0);
        tick("lkacc", 2'b11, 1, 1, 0, 0, 0);
        tick("lknext", 2'b10, 1, 1, 0, 0, 1);

        // Clear with count 3 and a lock on req1.
        tick("cl0", 2'b10, 1, 0, 0, 0, 1);
        tick("clr", 2'b11, 1, 1, 0, 1, 1);
        tick("clpost", 2'b11, 1, 1, 0, 0, 0);
        tick("cldrain", 2'b00, 1, 1, 1, 0, -1);

        // Unexpected done, sticky until clear.
        tick("ud0", 2'b00, 1, 1, 1, 0, -1);
        tick("ud1", 2'b00, 1, 1, 0, 0, -1);
        tick("ud2", 2'b00, 1, 1, 0, 1, -1);

        // Async reset mid-cycle with count 2 and error set.
        tick("ar0", 2'b00, 1, 1, 1, 0, -1);
        tick("ar1", 2'b01, 1, 1, 0, 0, 0);
        tick("ar2", 2'b10, 1, 1, 0, 0, 1);
        req_inst_wvalid = 2'b00;
        check("ar.pre_count", 64'(num_outstanding), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar.count", 64'(num_outstanding), 64'd0);
        check("ar.err", 64'(error_unexpected_done), 64'd0);
        sb.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick("ar3", 2'b11, 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dca_matrix_lsu_arbiter.md
# dca_matrix_lsu_arbiter

Round-robin arbiter that shares one matrix LSU instruction port (`BW_DCA_MATRIX_LSU_INST`-wide load/store instructions) between several instruction issuers inside a DCA matrix unit. Typical issuers are the load-side and store-side step sequencers. The block issues instructions in grant order and records the requester index of each issued instruction in an outstanding-ID FIFO. The LSU's in-order completion pulses are routed back to the requester that issued each instruction.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `BW_INST`, default `BW_DCA_MATRIX_LSU_INST`: instruction width.
- `MAX_OUTSTANDING`, default 4: depth of the outstanding-ID FIFO, a power of 2, at least 2.
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `clear`, input, 1: synchronous flush.
- `enable`, input, 1: when 0, no new instruction is issued.
- `req_inst_wvalid`, input, NUM_REQ: per-requester instruction valid.
- `req_inst_wready`, output, NUM_REQ: per-requester accept.
- `req_inst_wdata`, input, NUM_REQ*BW_INST: requester i occupies bits [i*BW_INST +: BW_INST].
- `req_inst_done`, output, NUM_REQ: one-cycle completion pulse to the issuing requester.
- `lsu_inst_wvalid`, output, 1: instruction valid toward the LSU.
- `lsu_inst_wready`, input, 1: LSU accept.
- `lsu_inst_wdata`, output, BW_INST: instruction toward the LSU.
- `lsu_inst_done`, input, 1: one pulse per completed instruction, in issue order.
- `busy`, output, 1: high when num_outstanding != 0 or any req_inst_wvalid is high.
- `num_outstanding`, output, clog2(MAX_OUTSTANDING)+1: FIFO occupancy.
- `error_unexpected_done`, output, 1: sticky error flag.

## Operation
- State:
  - rr_ptr: round-robin pointer.
  - lock and lock_idx: grant hold.
  - Outstanding-ID FIFO: entries of clog2(NUM_REQ) bits plus a count.
  - done_pending and done_idx: registered completion pulse.
- Requester rule: once valid is raised it must be held high, with data stable, until accepted.
- Grant selection, evaluated each cycle:
  - If lock=1, grant = lock_idx.
  - Otherwise grant = the first i with req_inst_wvalid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- Issue condition: can_issue = enable & (num_outstanding < MAX_OUTSTANDING) & a grant exists.
- Outputs while can_issue=1:
  - lsu_inst_wvalid = 1.
  - lsu_inst_wdata = the granted requester's data.
  - req_inst_wready[grant] = lsu_inst_wready; all other req_inst_wready bits are 0.
- Outputs while can_issue=0: lsu_inst_wvalid = 0, all req_inst_wready = 0, and lsu_inst_wdata holds the data of the lowest-index valid requester (don't care).
- Accepted handshake (lsu_inst_wvalid & lsu_inst_wready):
  - Push grant into the FIFO.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - lock <= 0.
- Stalled cycle (lsu_inst_wvalid & ~lsu_inst_wready): lock <= 1 and lock_idx <= grant. This prevents the grant from switching mid-handshake.
- Dropping enable while locked: lsu_inst_wvalid falls, lock is retained, and the same requester resumes when enable returns.
- lsu_inst_done with count > 0:
  - Pop the FIFO head.
  - Next cycle done_pending=1 with done_idx = the popped ID, so req_inst_done[done_idx] pulses for exactly one cycle.
- lsu_inst_done with count = 0: no pop, no req_inst_done pulse, error_unexpected_done <= 1 (sticky until rst or clear).
- Push and pop in the same cycle: the count is unchanged and FIFO ordering is preserved.
- Full FIFO: a pop in the same cycle does not enable an issue that cycle. can_issue uses the registered count.
- lsu_inst_done is processed regardless of enable.
- clear, synchronous with priority over all updates:
  - FIFO emptied, count=0.
  - rr_ptr=0, lock=0.
  - done_pending=0, error flag=0.
  - A handshake or done occurring in the same cycle as clear is discarded.
- Reset: all of the clear values above apply asynchronously. Every output is 0 during and immediately after reset, except outputs that combinationally follow inputs (wready, wvalid, wdata, busy) per the rules above with count=0 and lock=0.

## Timing
- Request to LSU valid: 0 cycles, combinational. Requester valid to wready is likewise combinational through lsu_inst_wready.
- Back-to-back issue at 1 instruction per cycle is supported.
- lsu_inst_done to req_inst_done: exactly 1 cycle.
- num_outstanding updates on the clock edge after the handshake or done.
- Fairness: with all requesters continuously valid and the LSU always ready, grants rotate 0,1,..,NUM_REQ-1,0,… with no requester skipped.

## Test plan
- Round-robin: NUM_REQ=2, both valid, LSU always ready, done never asserted. Grants go 0,1,0,1; the 5th instruction is blocked and num_outstanding=4 holds with lsu_inst_wvalid=0.
- Lock: req0 valid with lsu_inst_wready=0 for 3 cycles, then req1 rises. The grant stays on req0 and req0 is accepted on ready. The next grant goes to req1, and req0 data passes unchanged on lsu_inst_wdata throughout.
- Done routing: issue order 1,0,1, then 3 lsu_inst_done pulses. req_inst_done pulses 1,0,1, each exactly 1 cycle after its lsu_inst_done, and num_outstanding decrements 3→0.
- Simultaneous events: count=2, with a handshake and lsu_inst_done in the same cycle. Count stays 2 and the popped ID is the oldest. Repeat at count=4 (full): done plus a pending request gives no issue that cycle and issue on the next cycle.
- Unexpected done: lsu_inst_done with count=0 sets error_unexpected_done=1 and produces no req_inst_done pulse. The flag stays 1 until clear, then reads 0.
- Clear and reset mid-operation: count=3 and lock=1, assert clear. Next cycle count=0, lock=0, rr_ptr=0, and the next grant goes to req0. Assert rst asynchronously mid-cycle: count and the error flag drop immediately without waiting for a clock edge.
